divider: RTL

DIVIDER -- requirements
Module: divider

---
 rtl/div_pkg.sv | 18 +
 rtl/divider_if.sv | 25 ++
 rtl/div_step.sv | 24 ++
 rtl/divider.sv | 109 ++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared divider definitions: FSM state encoding, default iteration count and
// the operand magnitude helper used when latching a signed division.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_ITER_DEFAULT = 32;

    // Two's-complement magnitude only for negative signed operands.
    function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/divider_if.sv
// Execute-stage <-> divider handshake: operands and control from the pipeline,
// stall request and HILO result back to it.
interface divider_if;
    import div_pkg::*;

    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        stall_div;
    logic        ready;
    logic [63:0] result;

    modport master (
        output start, signed_div, a, b, annul,
        input  stall_div, ready, result
    );

    modport slave (
        input  start, signed_div, a, b, annul,
        output stall_div, ready, result
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, shift the quotient bit in.
module div_step (
    input  logic [31:0] rem_in,
    input  logic [31:0] quo_in,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic [31:0] quo_out
);

    logic [32:0] shifted;
    logic [31:0] diff;
    logic        fits;

    // The true difference is always below the divisor, so 32-bit wraparound is exact.
    always_comb begin
        shifted = {rem_in, quo_in[31]};
        fits    = (shifted >= {1'b0, divisor});
        diff    = shifted[31:0] - divisor;
        rem_out = fits ? diff : shifted[31:0];
        quo_out = {quo_in[30:0], fits};
    end

endmodule

// File: rtl/divider.sv
// Multi-cycle restoring divider for div/divu; stalls the front of the pipeline
// while busy and pulses ready with {remainder, quotient} for the HILO write.
module divider
    import div_pkg::*;
#(
    parameter int DIV_ITER = DIV_ITER_DEFAULT
) (
    input logic      clk,
    input logic      rst,
    divider_if.slave bus
);

    localparam logic [5:0] LAST_ITER = 6'(DIV_ITER - 1);

    div_state_e  state_q;
    div_state_e  state_d;
    logic [5:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dsr_q;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;
    logic        q_neg_q;
    logic        r_neg_q;
    logic [63:0] result_q;
    logic        accept;
    logic        last_step;

    div_step u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dsr_q),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // annul wins over everything, including a start presented in IDLE.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = (bus.b == 32'd0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == LAST_ITER) begin
                    last_step = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.annul) begin
            state_d   = IDLE;
            accept    = 1'b0;
            last_step = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= 6'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dsr_q    <= 32'd0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= 64'd0;
        end else if (accept) begin
            cnt_q   <= 6'd0;
            rem_q   <= 32'd0;
            quo_q   <= magnitude(bus.a, bus.signed_div);
            dsr_q   <= magnitude(bus.b, bus.signed_div);
            q_neg_q <= bus.signed_div & (bus.a[31] ^ bus.b[31]);
            r_neg_q <= bus.signed_div & bus.a[31];
            if (bus.b == 32'd0) begin
                result_q <= {bus.a, 32'hFFFF_FFFF};
            end
        end else if (state_q == BUSY && !bus.annul) begin
            cnt_q <= cnt_q + 6'd1;
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            // Signs are applied once, as the final iteration lands in DONE.
            if (last_step) begin
                result_q <= {r_neg_q ? (~rem_nx + 32'd1) : rem_nx,
                             q_neg_q ? (~quo_nx + 32'd1) : quo_nx};
            end
        end
    end

    assign bus.stall_div = rst && !bus.annul &&
                           ((state_q == IDLE && bus.start) || state_q == BUSY);
    assign bus.ready     = (state_q == DONE);
    assign bus.result    = result_q;

endmodule
